// File: rtl/kim_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kim_counter_pkg
// Description : Shared FSM state encoding and default widths for the counter
//               command sequencer and its command FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package kim_counter_pkg;

   // Default widths/depths used by the sequencer parameter list
   localparam int c_DEF_CNT_DATA_WIDTH = 7;
   localparam int c_DEF_FIFO_DEPTH     = 4;
   localparam int c_DEF_TAG_WIDTH      = 4;
   localparam int c_DEF_TIMEOUT        = 255;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_LAUNCH = 2'b01,
      ST_WAIT   = 2'b10,
      ST_RESP   = 2'b11
   } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/kim_counter_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : kim_counter_cmd_fifo
// Description : Synchronous first-word-fall-through command FIFO with a
//               registered occupancy level. Push when full and pop when empty
//               are ignored. DEPTH must be a power of two, >= 2, so the
//               pointers wrap naturally at their bit width.
// Revision    : 1.0 - initial release
// ============================================================================
module kim_counter_cmd_fifo #(
   parameter int DATA_WIDTH = 11,
   parameter int DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic [$clog2(DEPTH):0]  level_o
);

   localparam int                 c_PTR_W = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [c_PTR_W-1:0]    wr_ptr_q;
   logic [c_PTR_W-1:0]    rd_ptr_q;
   logic [c_PTR_W:0]      level_q;

   logic do_push;
   logic do_pop;

   assign do_push = push_i && (level_q != c_FULL);
   assign do_pop  = pop_i  && (level_q != '0);

   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;

   // Storage array: written at the tail on an accepted push, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers and level; a simultaneous push and pop leaves the level as is
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (do_push && !do_pop) begin
            level_q <= level_q + 1'b1;
         end else if (do_pop && !do_push) begin
            level_q <= level_q - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/kim_counter_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : kim_counter_cmd_seq
// Description : Queues counter commands {count, tag}, launches them one at a
//               time on the counter control stage, waits for done (with a
//               timeout) and returns a tagged completion with an error flag.
//               Zero-count commands complete immediately with an error.
// Revision    : 1.0 - initial release
// ============================================================================
module kim_counter_cmd_seq
   import kim_counter_pkg::*;
#(
   parameter int CNT_DATA_WIDTH = c_DEF_CNT_DATA_WIDTH,
   parameter int FIFO_DEPTH     = c_DEF_FIFO_DEPTH,
   parameter int TAG_WIDTH      = c_DEF_TAG_WIDTH,
   parameter int TIMEOUT        = c_DEF_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [CNT_DATA_WIDTH-1:0]     cmd_cnt_val,
   input  logic [TAG_WIDTH-1:0]          cmd_tag,
   output logic                          start_o,
   output logic [CNT_DATA_WIDTH-1:0]     cnt_val_o,
   input  logic                          run_i,
   input  logic                          done_i,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [TAG_WIDTH-1:0]          rsp_tag,
   output logic                          rsp_err,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

   localparam int                      c_LVL_W    = $clog2(FIFO_DEPTH) + 1;
   localparam int                      c_ENTRY_W  = CNT_DATA_WIDTH + TAG_WIDTH;
   localparam int                      c_WCNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [c_LVL_W-1:0]      c_LVL_FULL = c_LVL_W'(FIFO_DEPTH);
   localparam logic [c_WCNT_W-1:0]     c_WCNT_TMO = c_WCNT_W'(TIMEOUT);

   seq_state_e                  state_q;
   logic                        start_q;
   logic [CNT_DATA_WIDTH-1:0]   cnt_val_q;   // doubles as the current count
   logic [TAG_WIDTH-1:0]        cur_tag_q;
   logic                        rsp_valid_q;
   logic [TAG_WIDTH-1:0]        rsp_tag_q;
   logic                        rsp_err_q;
   logic [c_WCNT_W-1:0]         wait_cnt_q;
   logic [c_WCNT_W-1:0]         wait_cnt_d;

   logic                        push;
   logic                        pop;
   logic                        fifo_nonempty;
   logic [c_ENTRY_W-1:0]        head;
   logic [CNT_DATA_WIDTH-1:0]   head_cnt;
   logic [TAG_WIDTH-1:0]        head_tag;
   logic [c_LVL_W-1:0]          level;

   // run_i carries status only; nothing in the sequencer depends on it
   logic                        unused_run;
   assign unused_run = run_i;

   assign cmd_ready     = (level != c_LVL_FULL);
   assign push          = cmd_valid && cmd_ready;
   assign fifo_nonempty = (level != '0);
   assign pop           = (state_q == ST_IDLE) && fifo_nonempty;
   assign head_cnt      = head[c_ENTRY_W-1:TAG_WIDTH];
   assign head_tag      = head[TAG_WIDTH-1:0];
   assign wait_cnt_d    = wait_cnt_q + 1'b1;

   assign start_o       = start_q;
   assign cnt_val_o     = cnt_val_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_tag       = rsp_tag_q;
   assign rsp_err       = rsp_err_q;
   assign busy_o        = (state_q != ST_IDLE);
   assign fifo_level_o  = level;

   kim_counter_cmd_fifo #(
      .DATA_WIDTH (c_ENTRY_W),
      .DEPTH      (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({cmd_cnt_val, cmd_tag}),
      .rdata_o (head),
      .level_o (level)
   );

   // Command FSM with registered start/count/response outputs and wait timer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         start_q     <= 1'b0;
         cnt_val_q   <= '0;
         cur_tag_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_tag_q   <= '0;
         rsp_err_q   <= 1'b0;
         wait_cnt_q  <= '0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fifo_nonempty) begin
                  cnt_val_q <= head_cnt;
                  cur_tag_q <= head_tag;
                  if (head_cnt == '0) begin
                     // Nothing to count: report the error without launching
                     state_q     <= ST_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_tag_q   <= head_tag;
                     rsp_err_q   <= 1'b1;
                  end else begin
                     state_q <= ST_LAUNCH;
                     start_q <= 1'b1;
                  end
               end
            end
            ST_LAUNCH: begin
               state_q    <= ST_WAIT;
               wait_cnt_q <= '0;
            end
            ST_WAIT: begin
               wait_cnt_q <= wait_cnt_d;
               // done_i wins over a timeout landing in the same cycle
               if (done_i) begin
                  state_q     <= ST_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_tag_q   <= cur_tag_q;
                  rsp_err_q   <= 1'b0;
               end else if (wait_cnt_d == c_WCNT_TMO) begin
                  state_q     <= ST_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_tag_q   <= cur_tag_q;
                  rsp_err_q   <= 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
                  cnt_val_q   <= '0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_kim_counter_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_kim_counter_cmd_seq
// Description : Directed self-checking bench for kim_counter_cmd_seq
//               (TIMEOUT = 16, other parameters at their defaults).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kim_counter_cmd_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [6:0] cmd_cnt_val;
   logic [3:0] cmd_tag;
   logic       start_o;
   logic [6:0] cnt_val_o;
   logic       run_i;
   logic       done_i;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_tag;
   logic       rsp_err;
   logic       busy_o;
   logic [2:0] fifo_level_o;

   int errors = 0;
   int checks = 0;

   kim_counter_cmd_seq #(
      .CNT_DATA_WIDTH (7),
      .FIFO_DEPTH     (4),
      .TAG_WIDTH      (4),
      .TIMEOUT        (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_cnt_val  (cmd_cnt_val),
      .cmd_tag      (cmd_tag),
      .start_o      (start_o),
      .cnt_val_o    (cnt_val_o),
      .run_i        (run_i),
      .done_i       (done_i),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_tag      (rsp_tag),
      .rsp_err      (rsp_err),
      .busy_o       (busy_o),
      .fifo_level_o (fifo_level_o)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 ns later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_cnt_val = '0; cmd_tag = '0;
      run_i = 1'b0; done_i = 1'b0; rsp_ready = 1'b0;
      tick(); tick();
      checks++;
      if ({start_o, cnt_val_o, rsp_valid, rsp_tag, rsp_err, busy_o, cmd_ready, fifo_level_o}
          !== {1'b0, 7'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
         errors++;
         $display("FAIL reset_state: start=%b cnt=%0d rv=%b tag=%0d err=%b busy=%b rdy=%b lvl=%0d required 0 0 0 0 0 0 1 0",
                  start_o, cnt_val_o, rsp_valid, rsp_tag, rsp_err, busy_o, cmd_ready, fifo_level_o);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      cmd_valid = 1'b1; cmd_cnt_val = 7'd5; cmd_tag = 4'd3;
      tick();                                   // accept edge T
      cmd_valid = 1'b0;
      checks++;
      if ({start_o, busy_o, fifo_level_o} !== {1'b0, 1'b0, 3'd1}) begin
         errors++;
         $display("FAIL basic_accept: start=%b busy=%b lvl=%0d required 0 0 1", start_o, busy_o, fifo_level_o);
      end
      tick();                                   // pop edge T+1
      checks++;
      if ({start_o, cnt_val_o, busy_o, fifo_level_o} !== {1'b1, 7'd5, 1'b1, 3'd0}) begin
         errors++;
         $display("FAIL basic_launch: start=%b cnt=%0d busy=%b lvl=%0d required 1 5 1 0", start_o, cnt_val_o, busy_o, fifo_level_o);
      end
      tick();                                   // WAIT entry
      run_i = 1'b1;
      checks++;
      if ({start_o, cnt_val_o, rsp_valid} !== {1'b0, 7'd5, 1'b0}) begin
         errors++;
         $display("FAIL basic_single_pulse: start=%b cnt=%0d rv=%b required 0 5 0", start_o, cnt_val_o, rsp_valid);
      end
      tick(); tick(); tick();
      done_i = 1'b1;
      tick();
      done_i = 1'b0; run_i = 1'b0;
      checks++;
      if ({rsp_valid, rsp_tag, rsp_err, cnt_val_o, busy_o, start_o} !== {1'b1, 4'd3, 1'b0, 7'd5, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL basic_resp: rv=%b tag=%0d err=%b cnt=%0d busy=%b start=%b required 1 3 0 5 1 0",
                  rsp_valid, rsp_tag, rsp_err, cnt_val_o, busy_o, start_o);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if ({rsp_valid, busy_o, cnt_val_o} !== {1'b0, 1'b0, 7'd0}) begin
         errors++;
         $display("FAIL basic_drain: rv=%b busy=%b cnt=%0d required 0 0 0", rsp_valid, busy_o, cnt_val_o);
      end
   endtask

   task automatic test_zero_count();
      cmd_valid = 1'b1; cmd_cnt_val = 7'd0; cmd_tag = 4'd7;
      tick();
      cmd_valid = 1'b0;
      checks++;
      if ({start_o, rsp_valid, fifo_level_o} !== {1'b0, 1'b0, 3'd1}) begin
         errors++;
         $display("FAIL zero_accept: start=%b rv=%b lvl=%0d required 0 0 1", start_o, rsp_valid, fifo_level_o);
      end
      tick();
      checks++;
      if ({start_o, rsp_valid, rsp_tag, rsp_err, cnt_val_o, busy_o} !== {1'b0, 1'b1, 4'd7, 1'b1, 7'd0, 1'b1}) begin
         errors++;
         $display("FAIL zero_resp: start=%b rv=%b tag=%0d err=%b cnt=%0d busy=%b required 0 1 7 1 0 1",
                  start_o, rsp_valid, rsp_tag, rsp_err, cnt_val_o, busy_o);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if ({rsp_valid, busy_o, start_o} !== {1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL zero_drain: rv=%b busy=%b start=%b required 0 0 0", rsp_valid, busy_o, start_o);
      end
   endtask

   // Wait (bounded) for the next launch, finish it with done_i, drain the response
   task automatic run_one(input logic [3:0] exp_tag);
      int n = 0;
      while (start_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (start_o !== 1'b1) begin
         errors++;
         $display("FAIL run_one_start tag=%0d: start=%b required 1 within 20 cycles", exp_tag, start_o);
      end else begin
         tick();
         done_i = 1'b1;
         tick();
         done_i = 1'b0;
         checks++;
         if ({rsp_valid, rsp_tag, rsp_err} !== {1'b1, exp_tag, 1'b0}) begin
            errors++;
            $display("FAIL run_one_resp: rv=%b tag=%0d err=%b required 1 %0d 0", rsp_valid, rsp_tag, rsp_err, exp_tag);
         end
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
      end
   endtask

   // Fill the FIFO behind a stalled response, then drain everything in order
   task automatic test_full_and_stall();
      // Tag 1 (zero count) parks in RESP; tags 2..5 fill the FIFO
      for (int i = 1; i <= 5; i++) begin
         cmd_valid   = 1'b1;
         cmd_cnt_val = (i == 1) ? 7'd0 : 7'd3;
         cmd_tag     = i[3:0];
         checks++;
         if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_ready_before_push%0d: cmd_ready=%b required 1", i, cmd_ready);
         end
         tick();
      end
      // Extra command held on the bus while the FIFO is full
      cmd_cnt_val = 7'd3; cmd_tag = 4'd6;
      checks++;
      if ({fifo_level_o, cmd_ready, rsp_valid, rsp_tag, rsp_err} !== {3'd4, 1'b0, 1'b1, 4'd1, 1'b1}) begin
         errors++;
         $display("FAIL full_level: lvl=%0d rdy=%b rv=%b tag=%0d err=%b required 4 0 1 1 1",
                  fifo_level_o, cmd_ready, rsp_valid, rsp_tag, rsp_err);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if ({rsp_valid, rsp_tag, rsp_err, start_o, fifo_level_o, cmd_ready} !== {1'b1, 4'd1, 1'b1, 1'b0, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL stall_cycle%0d: rv=%b tag=%0d err=%b start=%b lvl=%0d rdy=%b required 1 1 1 0 4 0",
                     i, rsp_valid, rsp_tag, rsp_err, start_o, fifo_level_o, cmd_ready);
         end
      end
      rsp_ready = 1'b1;
      tick();                                   // handshake edge
      rsp_ready = 1'b0;
      checks++;
      if ({rsp_valid, busy_o, fifo_level_o, cmd_ready} !== {1'b0, 1'b0, 3'd4, 1'b0}) begin
         errors++;
         $display("FAIL full_after_handshake: rv=%b busy=%b lvl=%0d rdy=%b required 0 0 4 0",
                  rsp_valid, busy_o, fifo_level_o, cmd_ready);
      end
      tick();                                   // pop of tag 2
      checks++;
      if ({fifo_level_o, cmd_ready, start_o, cnt_val_o} !== {3'd3, 1'b1, 1'b1, 7'd3}) begin
         errors++;
         $display("FAIL full_pop: lvl=%0d rdy=%b start=%b cnt=%0d required 3 1 1 3",
                  fifo_level_o, cmd_ready, start_o, cnt_val_o);
      end
      tick();                                   // held command accepted
      cmd_valid = 1'b0;
      checks++;
      if (fifo_level_o !== 3'd4) begin
         errors++;
         $display("FAIL full_late_accept: lvl=%0d required 4", fifo_level_o);
      end
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      checks++;
      if ({rsp_valid, rsp_tag, rsp_err} !== {1'b1, 4'd2, 1'b0}) begin
         errors++;
         $display("FAIL full_resp_tag2: rv=%b tag=%0d err=%b required 1 2 0", rsp_valid, rsp_tag, rsp_err);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      for (int t = 3; t <= 6; t++) begin
         run_one(t[3:0]);
      end
      checks++;
      if ({fifo_level_o, busy_o, cmd_ready} !== {3'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL full_all_drained: lvl=%0d busy=%b rdy=%b required 0 0 1", fifo_level_o, busy_o, cmd_ready);
      end
   endtask

   // Withhold done_i: timeout after 16 WAIT cycles; then done_i on the 16th cycle
   task automatic test_timeout();
      for (int pass = 0; pass < 2; pass++) begin
         cmd_valid = 1'b1; cmd_cnt_val = 7'd9; cmd_tag = (pass == 0) ? 4'd9 : 4'd10;
         tick();                                // accept
         cmd_valid = 1'b0;
         tick();                                // pop -> LAUNCH
         tick();                                // WAIT entry edge
         for (int k = 1; k <= 15; k++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0) begin
               errors++;
               $display("FAIL timeout_early pass%0d cycle%0d: rv=%b required 0", pass, k, rsp_valid);
            end
         end
         done_i = (pass == 1);
         tick();                                // 16 edges after WAIT entry
         done_i = 1'b0;
         checks++;
         if ({rsp_valid, rsp_tag, rsp_err} !== {1'b1, ((pass == 0) ? 4'd9 : 4'd10), (pass == 0)}) begin
            errors++;
            $display("FAIL timeout_resp pass%0d: rv=%b tag=%0d err=%b required 1 %0d %0d",
                     pass, rsp_valid, rsp_tag, rsp_err, (pass == 0) ? 9 : 10, (pass == 0) ? 1 : 0);
         end
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
      end
   endtask

   // Reset asserted mid-WAIT with two commands queued
   task automatic test_reset_mid();
      bit seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cmd_valid = 1'b1; cmd_cnt_val = 7'd4; cmd_tag = 4'(11 + i);
         tick();
      end
      cmd_valid = 1'b0;
      tick();
      checks++;
      if ({busy_o, fifo_level_o, start_o} !== {1'b1, 3'd2, 1'b0}) begin
         errors++;
         $display("FAIL rstmid_setup: busy=%b lvl=%0d start=%b required 1 2 0", busy_o, fifo_level_o, start_o);
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if ({start_o, cnt_val_o, rsp_valid, rsp_tag, rsp_err, busy_o, cmd_ready, fifo_level_o}
          !== {1'b0, 7'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
         errors++;
         $display("FAIL rstmid_outputs: start=%b cnt=%0d rv=%b tag=%0d err=%b busy=%b rdy=%b lvl=%0d required 0 0 0 0 0 0 1 0",
                  start_o, cnt_val_o, rsp_valid, rsp_tag, rsp_err, busy_o, cmd_ready, fifo_level_o);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         done_i = (i % 5 == 2);
         run_i  = (i % 3 == 0);
         tick();
         if (rsp_valid || start_o || busy_o || (fifo_level_o != 3'd0)) seen = 1'b1;
      end
      done_i = 1'b0; run_i = 1'b0;
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_no_activity: activity seen=%b required 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_count();
      test_full_and_stall();
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
